// File: rtl/walker_pkg.sv
// Shared types and defaults for the page-walker arbiter and the walker it fronts.
package walker_pkg;

    typedef enum logic [1:0] {ARB_IDLE, ARB_ISSUE, ARB_WAIT, ARB_RESP} arb_state_e;

    localparam int unsigned DEF_VA_W = 32;
    localparam int unsigned DEF_PA_W = 28;

    // Index width for n requesters; a single requester still needs one bit.
    function automatic int unsigned id_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/walker_arb_if.sv
// Requester and walker handshake bundle for walker_arb.
// slave is the arbiter's view; master is the requesters/walker side.
interface walker_arb_if #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned VA_W    = walker_pkg::DEF_VA_W,
    parameter int unsigned PA_W    = walker_pkg::DEF_PA_W
);

    logic [NUM_REQ*VA_W-1:0] req_va_i;
    logic [NUM_REQ-1:0]      req_vld_i;
    logic [NUM_REQ-1:0]      req_rdy_o;
    logic [PA_W-1:0]         rsp_pa_o;
    logic                    rsp_fault_o;
    logic [NUM_REQ-1:0]      rsp_vld_o;
    logic [NUM_REQ-1:0]      rsp_rdy_i;
    logic [VA_W-1:0]         wk_va_o;
    logic                    wk_va_vld_o;
    logic                    wk_va_rdy_i;
    logic [PA_W-1:0]         wk_pa_i;
    logic                    wk_pa_vld_i;
    logic                    wk_pa_fault_i;
    logic                    wk_pa_rdy_o;

    modport slave (
        input  req_va_i, req_vld_i, rsp_rdy_i, wk_va_rdy_i, wk_pa_i, wk_pa_vld_i, wk_pa_fault_i,
        output req_rdy_o, rsp_pa_o, rsp_fault_o, rsp_vld_o, wk_va_o, wk_va_vld_o, wk_pa_rdy_o
    );

    modport master (
        output req_va_i, req_vld_i, rsp_rdy_i, wk_va_rdy_i, wk_pa_i, wk_pa_vld_i, wk_pa_fault_i,
        input  req_rdy_o, rsp_pa_o, rsp_fault_o, rsp_vld_o, wk_va_o, wk_va_vld_o, wk_pa_rdy_o
    );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set bit of req searching upward from ptr, with wrap.
module rr_pick import walker_pkg::*; #(
    parameter  int unsigned N    = 4,
    localparam int unsigned ID_W = id_width(N)
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] ptr,
    output logic [N-1:0]    onehot,
    output logic [ID_W-1:0] idx,
    output logic            any
);

    logic [ID_W-1:0] cand;

    always_comb begin
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        cand   = '0;
        for (int unsigned i = 0; i < N; i++) begin
            cand = ID_W'((32'(ptr) + i) % N);
            if (!any && req[cand]) begin
                onehot[cand] = 1'b1;
                idx          = cand;
                any          = 1'b1;
            end
        end
    end

endmodule

// File: rtl/walker_arb.sv
// Round-robin arbiter sharing one single-outstanding page walker among NUM_REQ requesters.
// Optional per-requester fault counters: define WALKER_ARB_FAULT_CNT_EN.
module walker_arb import walker_pkg::*; #(
    parameter  int unsigned NUM_REQ = 4,
    parameter  int unsigned VA_W    = DEF_VA_W,
    parameter  int unsigned PA_W    = DEF_PA_W,
    localparam int unsigned ID_W    = id_width(NUM_REQ)
) (
    input  logic                  clk_i,
    input  logic                  resetn_i,
    walker_arb_if.slave           bus,
`ifdef WALKER_ARB_FAULT_CNT_EN
    output logic [NUM_REQ*16-1:0] fault_cnt_o,
`endif
    output logic [ID_W-1:0]       owner_o,
    output logic                  busy_o,
    output logic                  proto_err_o
);

    arb_state_e         state_q, state_d;
    logic [VA_W-1:0]    va_q, va_d;
    logic [PA_W-1:0]    pa_q, pa_d;
    logic               fault_q, fault_d;
    logic [ID_W-1:0]    owner_q, owner_d;
    logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic               proto_err_q;

    logic [NUM_REQ-1:0] grant_oh;
    logic [ID_W-1:0]    grant_idx;
    logic               grant_any;
    logic [NUM_REQ-1:0] rsp_vld;
    logic               rsp_done;
    logic [VA_W-1:0]    req_va [NUM_REQ];

    for (genvar k = 0; k < NUM_REQ; k++) begin : g_port
        assign req_va[k]  = bus.req_va_i[k*VA_W +: VA_W];
        assign rsp_vld[k] = (state_q == ARB_RESP) && (owner_q == ID_W'(k));
    end

    rr_pick #(
        .N (NUM_REQ)
    ) u_pick (
        .req    (bus.req_vld_i),
        .ptr    (rr_ptr_q),
        .onehot (grant_oh),
        .idx    (grant_idx),
        .any    (grant_any)
    );

    // Only the owner's ready completes a response; other ports' ready is don't-care.
    assign rsp_done = |(rsp_vld & bus.rsp_rdy_i);

    always_comb begin
        state_d  = state_q;
        va_d     = va_q;
        pa_d     = pa_q;
        fault_d  = fault_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        unique case (state_q)
            ARB_IDLE: begin
                if (grant_any) begin
                    va_d    = req_va[grant_idx];
                    owner_d = grant_idx;
                    state_d = ARB_ISSUE;
                end
            end
            ARB_ISSUE: begin
                if (bus.wk_va_rdy_i) state_d = ARB_WAIT;
            end
            ARB_WAIT: begin
                if (bus.wk_pa_vld_i) begin
                    pa_d    = bus.wk_pa_i;
                    fault_d = bus.wk_pa_fault_i;
                    state_d = ARB_RESP;
                end
            end
            ARB_RESP: begin
                if (rsp_done) begin
                    rr_ptr_d = (owner_q == ID_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
                    state_d  = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state_q     <= ARB_IDLE;
            va_q        <= '0;
            pa_q        <= '0;
            fault_q     <= 1'b0;
            owner_q     <= '0;
            rr_ptr_q    <= '0;
            proto_err_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            va_q     <= va_d;
            pa_q     <= pa_d;
            fault_q  <= fault_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
            if (bus.wk_pa_vld_i && (state_q != ARB_WAIT)) proto_err_q <= 1'b1;
        end
    end

    // Never signal accept while in reset: the request would not be captured.
    assign bus.req_rdy_o   = (state_q == ARB_IDLE && resetn_i) ? grant_oh : '0;
    assign bus.wk_va_o     = va_q;
    assign bus.wk_va_vld_o = (state_q == ARB_ISSUE);
    assign bus.wk_pa_rdy_o = (state_q == ARB_WAIT);
    assign bus.rsp_vld_o   = rsp_vld;
    assign bus.rsp_pa_o    = pa_q;
    assign bus.rsp_fault_o = fault_q;
    assign owner_o         = owner_q;
    assign busy_o          = (state_q != ARB_IDLE);
    assign proto_err_o     = proto_err_q;

`ifdef WALKER_ARB_FAULT_CNT_EN
    for (genvar k = 0; k < NUM_REQ; k++) begin : g_fault_cnt
        logic [15:0] cnt_q;
        always_ff @(posedge clk_i or negedge resetn_i) begin
            if (!resetn_i) begin
                cnt_q <= '0;
            end else if (rsp_vld[k] && bus.rsp_rdy_i[k] && fault_q && (cnt_q != 16'hFFFF)) begin
                cnt_q <= cnt_q + 16'd1;
            end
        end
        assign fault_cnt_o[k*16 +: 16] = cnt_q;
    end
`endif

endmodule

// File: tb/tb_walker_arb.sv
// Directed bench for walker_arb: bench plays requesters and walker, scoreboard holds
// expected responses pushed at grant time and popped when the response appears.
module tb_walker_arb;

    localparam int unsigned NR = 4;
    localparam int unsigned VW = 32;
    localparam int unsigned PW = 28;

    typedef struct packed {
        logic [1:0]    port;
        logic [PW-1:0] pa;
        logic          fault;
    } exp_t;

    logic          clk_i    = 1'b0;
    logic          resetn_i = 1'b0;
    logic [1:0]    owner;
    logic          busy;
    logic          perr;
`ifdef WALKER_ARB_FAULT_CNT_EN
    logic [NR*16-1:0] fcnt;
`endif

    walker_arb_if #(.NUM_REQ(NR), .VA_W(VW), .PA_W(PW)) bus ();

    walker_arb #(
        .NUM_REQ (NR),
        .VA_W    (VW),
        .PA_W    (PW)
    ) dut (
        .clk_i       (clk_i),
        .resetn_i    (resetn_i),
        .bus         (bus),
`ifdef WALKER_ARB_FAULT_CNT_EN
        .fault_cnt_o (fcnt),
`endif
        .owner_o     (owner),
        .busy_o      (busy),
        .proto_err_o (perr)
    );

    always #5 clk_i = ~clk_i;

    int   checks    = 0;
    int   errors    = 0;
    int   va_xfers  = 0;
    int   rsp_xfers = 0;
    exp_t sb[$];

    always @(posedge clk_i) begin
        if (bus.wk_va_vld_o && bus.wk_va_rdy_i) va_xfers <= va_xfers + 1;
        if (|(bus.rsp_vld_o & bus.rsp_rdy_i)) rsp_xfers <= rsp_xfers + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_va(input int port, input logic [VW-1:0] va);
        bus.req_va_i[port*VW +: VW] = va;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".req_rdy"}, bus.req_rdy_o, 0);
        chk({tag, ".rsp_vld"}, bus.rsp_vld_o, 0);
        chk({tag, ".rsp_pa"}, bus.rsp_pa_o, 0);
        chk({tag, ".rsp_fault"}, bus.rsp_fault_o, 0);
        chk({tag, ".wk_va"}, bus.wk_va_o, 0);
        chk({tag, ".wk_va_vld"}, bus.wk_va_vld_o, 0);
        chk({tag, ".wk_pa_rdy"}, bus.wk_pa_rdy_o, 0);
        chk({tag, ".owner"}, owner, 0);
        chk({tag, ".busy"}, busy, 0);
        chk({tag, ".proto_err"}, perr, 0);
`ifdef WALKER_ARB_FAULT_CNT_EN
        chk({tag, ".fault_cnt"}, fcnt, 0);
`endif
    endtask

    // One full walk; called at edge+1 with the requester(s) already driven.
    task automatic run_walk(input int port, input logic [VW-1:0] va, input logic [PW-1:0] pa,
                            input logic fault, input int va_stall, input int rsp_stall,
                            input bit drop);
        logic [NR-1:0] oh;
        exp_t          e;
        int            n;
        oh = NR'(1) << port;
        n  = 0;
        #1;
        while (bus.req_rdy_o == '0 && n < 50) begin
            step();
            n++;
        end
        chk("grant", bus.req_rdy_o, oh);
        sb.push_back('{port: 2'(port), pa: pa, fault: fault});
        step();
        if (drop) bus.req_vld_i[port] = 1'b0;
        chk("issue.vld", bus.wk_va_vld_o, 1);
        chk("issue.va", bus.wk_va_o, va);
        chk("issue.owner", owner, port);
        chk("issue.busy", busy, 1);
        chk("issue.no_rdy", bus.req_rdy_o, 0);
        repeat (va_stall) begin
            step();
            chk("va_hold.vld", bus.wk_va_vld_o, 1);
            chk("va_hold.va", bus.wk_va_o, va);
        end
        bus.wk_va_rdy_i = 1'b1;
        step();
        bus.wk_va_rdy_i = 1'b0;
        chk("wait.pa_rdy", bus.wk_pa_rdy_o, 1);
        chk("wait.va_vld", bus.wk_va_vld_o, 0);
        bus.wk_pa_vld_i   = 1'b1;
        bus.wk_pa_i       = pa;
        bus.wk_pa_fault_i = fault;
        step();
        bus.wk_pa_vld_i   = 1'b0;
        bus.wk_pa_i       = ~pa;
        bus.wk_pa_fault_i = ~fault;
        bus.rsp_rdy_i     = ~oh;
        #1;
        repeat (rsp_stall) begin
            chk("rsp_hold.vld", bus.rsp_vld_o, oh);
            chk("rsp_hold.pa", bus.rsp_pa_o, pa);
            step();
        end
        e = sb.pop_front();
        chk("rsp.vld", bus.rsp_vld_o, NR'(1) << e.port);
        chk("rsp.pa", bus.rsp_pa_o, e.pa);
        chk("rsp.fault", bus.rsp_fault_o, e.fault);
        bus.rsp_rdy_i = oh;
        step();
        bus.rsp_rdy_i = '0;
        chk("done.busy", busy, 0);
        chk("done.rsp_vld", bus.rsp_vld_o, 0);
        chk("done.pa_held", bus.rsp_pa_o, pa);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int va0, rs0;
        bus.req_va_i      = '0;
        bus.req_vld_i     = '0;
        bus.rsp_rdy_i     = '0;
        bus.wk_va_rdy_i   = 1'b0;
        bus.wk_pa_i       = '0;
        bus.wk_pa_vld_i   = 1'b0;
        bus.wk_pa_fault_i = 1'b0;

        #7;
        chk_zero("reset");
        #6;
        resetn_i = 1'b1;
        step();

        // Single request, port 2.
        set_va(2, 32'h1234_5ABC);
        bus.req_vld_i[2] = 1'b1;
        run_walk(2, 32'h1234_5ABC, 28'hABC_D5BC, 1'b0, 0, 0, 1'b1);

        // Fairness from a fresh rr pointer.
        resetn_i = 1'b0;
        #1;
        resetn_i = 1'b1;
        step();
        for (int k = 0; k < 4; k++) set_va(k, 32'h1000_0000 + 32'(k));
        bus.req_vld_i = 4'hF;
        for (int i = 0; i < 8; i++) begin
            run_walk(i % 4, 32'h1000_0000 + 32'(i % 4), 28'h200_0000 + 28'(i), 1'b0, 0, 0, 1'b0);
        end
        bus.req_vld_i = '0;

        // Backpressure on both walker VA side and response side.
        va0 = va_xfers;
        rs0 = rsp_xfers;
        set_va(1, 32'hDEAD_BEEF);
        bus.req_vld_i[1] = 1'b1;
        run_walk(1, 32'hDEAD_BEEF, 28'h55A_A55A, 1'b0, 5, 3, 1'b1);
        chk("bp.va_xfers", va_xfers - va0, 1);
        chk("bp.rsp_xfers", rsp_xfers - rs0, 1);

        // Faulting walk on port 1.
        set_va(1, 32'h0BAD_F00D);
        bus.req_vld_i[1] = 1'b1;
        run_walk(1, 32'h0BAD_F00D, 28'h123_4567, 1'b1, 0, 1, 1'b1);
`ifdef WALKER_ARB_FAULT_CNT_EN
        chk("fcnt.port1", fcnt[31:16], 1);
        chk("fcnt.port0", fcnt[15:0], 0);
`endif

        // Stray walker PA in IDLE.
        bus.wk_pa_vld_i = 1'b1;
        bus.wk_pa_i     = 28'hFFF_FFFF;
        #1;
        chk("perr.pa_rdy", bus.wk_pa_rdy_o, 0);
        chk("perr.before", perr, 0);
        step();
        bus.wk_pa_vld_i = 1'b0;
        chk("perr.set", perr, 1);
        chk("perr.idle", busy, 0);
        chk("perr.pa_kept", bus.rsp_pa_o, 28'h123_4567);
        step();
        step();
        chk("perr.sticky", perr, 1);
        set_va(0, 32'h0000_CAFE);
        bus.req_vld_i[0] = 1'b1;
        run_walk(0, 32'h0000_CAFE, 28'h00C_AFE0, 1'b0, 1, 0, 1'b1);
        chk("perr.after_walk", perr, 1);

        // Asynchronous reset while the walk is in WAIT.
        set_va(3, 32'h3333_3333);
        bus.req_vld_i[3] = 1'b1;
        #1;
        chk("ar.grant", bus.req_rdy_o, 4'b1000);
        step();
        bus.req_vld_i[3] = 1'b0;
        bus.wk_va_rdy_i  = 1'b1;
        step();
        bus.wk_va_rdy_i  = 1'b0;
        chk("ar.in_wait", bus.wk_pa_rdy_o, 1);
        #1;
        resetn_i = 1'b0;
        #1;
        chk_zero("async_reset");
        #1;
        resetn_i = 1'b1;
        step();
        // Ports 0 and 3 both valid: a cleared pointer must pick 0 first, then 3.
        set_va(0, 32'h0000_0100);
        set_va(3, 32'h3000_0300);
        bus.req_vld_i = 4'b1001;
        run_walk(0, 32'h0000_0100, 28'h000_0010, 1'b0, 0, 0, 1'b1);
        run_walk(3, 32'h3000_0300, 28'h300_0030, 1'b0, 0, 0, 1'b1);
        chk("sb.empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
